// File: rtl/rv32i_control_decoder.sv
// RV32I ID-stage control decoder: combinational 20-bit control word plus an ID/EX register with stall/flush.
// Optional macro CU_STRICT_FUNCT7_EN makes non-canonical funct7 / shift-immediate encodings illegal.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 20
`endif

module rv32i_control_decoder #(
  parameter int CTRL_W = `CONTROL_SIGNALS_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              flush,
  output logic [CTRL_W-1:0] control_signals,
  output logic [CTRL_W-1:0] control_signals_q
);

  localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010, ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_OR = 4'b1000, ALU_AND = 4'b1001, ALU_PASS_B = 4'b1010;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_bits;

  assign w_opcode      = instruction[6:0];
  assign w_funct3      = instruction[14:12];
  assign w_funct7      = instruction[31:25];
  assign w_unused_bits = ^instruction[24:7];

  logic       w_illegal, w_jump, w_branch, w_a_pc, w_b_imm, w_reg_write;
  logic [1:0] w_result_sel;
  logic [3:0] w_mem_br_op, w_alu_ctrl;
  logic       w_f7_ok_reg, w_f7_ok_imm;

  // Shared funct3 -> ALU mapping; funct7[5] only matters for ADD/SUB (register form) and SRL/SRA.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  alu_from_funct3 = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct3 = ALU_SLL;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b011:  alu_from_funct3 = ALU_SLTU;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b101:  alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct3 = ALU_OR;
      default: alu_from_funct3 = ALU_AND;
    endcase
  endfunction

`ifdef CU_STRICT_FUNCT7_EN
  assign w_f7_ok_reg = (w_funct7 == 7'b0000000) ||
                       ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
  assign w_f7_ok_imm = (w_funct3 == 3'b001) ? (w_funct7 == 7'b0000000) :
                       (w_funct3 == 3'b101) ? ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000)) :
                       1'b1;
`else
  assign w_f7_ok_reg = 1'b1;
  assign w_f7_ok_imm = 1'b1;
`endif

  always_comb begin
    w_illegal    = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_a_pc       = 1'b0;
    w_b_imm      = 1'b0;
    w_reg_write  = 1'b0;
    w_result_sel = 2'b00;
    w_mem_br_op  = 4'b0000;
    w_alu_ctrl   = ALU_ADD;
    case (w_opcode)
      OP_REG: begin
        w_reg_write = 1'b1;
        w_alu_ctrl  = alu_from_funct3(w_funct3, w_funct7[5], 1'b1);
        w_illegal   = !w_f7_ok_reg;
      end
      OP_IMM: begin
        w_reg_write = 1'b1;
        w_b_imm     = 1'b1;
        w_alu_ctrl  = alu_from_funct3(w_funct3, w_funct7[5], 1'b0);
        w_illegal   = !w_f7_ok_imm;
      end
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_result_sel = 2'b01;
        w_b_imm      = 1'b1;
        case (w_funct3)
          3'b000:  w_mem_br_op = 4'b0010;
          3'b001:  w_mem_br_op = 4'b0100;
          3'b010:  w_mem_br_op = 4'b0011;
          3'b100:  w_mem_br_op = 4'b1001;
          3'b101:  w_mem_br_op = 4'b1101;
          default: w_illegal   = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_b_imm = 1'b1;
        case (w_funct3)
          3'b000:  w_mem_br_op = 4'b1010;
          3'b001:  w_mem_br_op = 4'b1011;
          3'b010:  w_mem_br_op = 4'b1100;
          default: w_illegal   = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        w_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_mem_br_op = 4'b0001;
          3'b001:  w_mem_br_op = 4'b0101;
          3'b100:  w_mem_br_op = 4'b0110;
          3'b101:  w_mem_br_op = 4'b0111;
          3'b110:  w_mem_br_op = 4'b1110;
          3'b111:  w_mem_br_op = 4'b1111;
          default: w_illegal   = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_sel = 2'b11;
        // JALR adds rs1+imm in the ALU; JAL forms PC+imm in the branch adder.
        w_b_imm      = (w_opcode == OP_JALR);
        w_illegal    = (w_opcode == OP_JALR) && (w_funct3 != 3'b000);
      end
      OP_LUI: begin
        w_reg_write = 1'b1;
        w_b_imm     = 1'b1;
        w_alu_ctrl  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        w_reg_write = 1'b1;
        w_a_pc      = 1'b1;
        w_b_imm     = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign control_signals = w_illegal ? {1'b1, {(CTRL_W-1){1'b0}}} :
                           {1'b0, w_result_sel[1], w_jump, w_branch, w_mem_br_op, w_a_pc, w_b_imm,
                            4'b0000, w_alu_ctrl, w_result_sel[0], w_reg_write};

  logic [CTRL_W-1:0] r_ctrl_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_ctrl_q <= '0;
    else if (flush)  r_ctrl_q <= '0;
    else if (!stall) r_ctrl_q <= control_signals;
  end

  assign control_signals_q = r_ctrl_q;

endmodule

// File: tb/tb_rv32i_control_decoder.sv
// Scoreboard bench for rv32i_control_decoder: stimulus queues expected words, a negedge monitor checks them.
// Expectation for the funct7 check follows CU_STRICT_FUNCT7_EN.
`timescale 1ns/1ps

module tb_rv32i_control_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic [19:0] control_signals;
  logic [19:0] control_signals_q;

  rv32i_control_decoder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instruction       (instruction),
    .stall             (stall),
    .flush             (flush),
    .control_signals   (control_signals),
    .control_signals_q (control_signals_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CU_STRICT_FUNCT7_EN
  localparam logic [19:0] EXP_F7_ADD  = 20'h80000;
  localparam logic [19:0] EXP_F7_SLLI = 20'h80000;
`else
  localparam logic [19:0] EXP_F7_ADD  = 20'h00001;
  localparam logic [19:0] EXP_F7_SLLI = 20'h00409;
`endif

  typedef struct {
    int unsigned cyc;
    bit          is_q;
    logic [19:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Comb result is due in the issue cycle; the registered copy one edge later.
  task automatic drive(input logic [31:0] ins, input logic rn, input logic st, input logic fl,
                       input logic [19:0] exp_c, input logic [19:0] exp_q, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    instruction = ins;
    rst_n       = rn;
    stall       = st;
    flush       = fl;
    e.cyc = cyc;     e.is_q = 1'b0; e.exp = exp_c; e.name = name; sb.push_back(e);
    e.cyc = cyc + 1; e.is_q = 1'b1; e.exp = exp_q; e.name = name; sb.push_back(e);
  endtask

  exp_t        mon_e;
  logic [19:0] mon_act;

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = mon_e.is_q ? control_signals_q : control_signals;
      n_cmp++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s%s: got %05h expected %05h (cycle %0d due %0d)",
                 mon_e.name, mon_e.is_q ? "_q" : "", mon_act, mon_e.exp, cyc, mon_e.cyc);
      end else begin
        $display("ok   %s%s: %05h", mon_e.name, mon_e.is_q ? "_q" : "", mon_act);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    instruction = 32'h0;
    repeat (2) @(posedge clk);

    // Register reset, release, stall and flush priority
    drive(32'h00002003, 1'b0, 1'b0, 1'b0, 20'h03403, 20'h00000, "rst_lw");
    drive(32'h00002003, 1'b1, 1'b0, 1'b0, 20'h03403, 20'h03403, "lw_load");
    drive(32'h00002023, 1'b1, 1'b1, 1'b0, 20'h0C400, 20'h03403, "sw_stall");
    drive(32'h00002023, 1'b1, 1'b1, 1'b1, 20'h0C400, 20'h00000, "stall_flush");
    drive(32'h00000033, 1'b1, 1'b0, 1'b1, 20'h00001, 20'h00000, "add_flush");
    drive(32'h00000033, 1'b0, 1'b1, 1'b1, 20'h00001, 20'h00000, "rst_over_all");

    // Decode vectors; the register simply follows
    drive(32'h00000033, 1'b1, 1'b0, 1'b0, 20'h00001, 20'h00001, "add");
    drive(32'h00000013, 1'b1, 1'b0, 1'b0, 20'h00401, 20'h00401, "addi");
    drive(32'h00002003, 1'b1, 1'b0, 1'b0, 20'h03403, 20'h03403, "lw");
    drive(32'h00002023, 1'b1, 1'b0, 1'b0, 20'h0C400, 20'h0C400, "sw");
    drive(32'h00000063, 1'b1, 1'b0, 1'b0, 20'h11000, 20'h11000, "beq");
    drive(32'h0000006F, 1'b1, 1'b0, 1'b0, 20'h60003, 20'h60003, "jal");
    drive(32'h40000033, 1'b1, 1'b0, 1'b0, 20'h00005, 20'h00005, "sub");
    drive(32'h00000067, 1'b1, 1'b0, 1'b0, 20'h60403, 20'h60403, "jalr");
    drive(32'h000000B7, 1'b1, 1'b0, 1'b0, 20'h00429, 20'h00429, "lui");
    drive(32'h00001063, 1'b1, 1'b0, 1'b0, 20'h15000, 20'h15000, "bne");
    drive(32'h00000017, 1'b1, 1'b0, 1'b0, 20'h00C01, 20'h00C01, "auipc");
    drive(32'h40005013, 1'b1, 1'b0, 1'b0, 20'h0041D, 20'h0041D, "srai");
    drive(32'h40005033, 1'b1, 1'b0, 1'b0, 20'h0001D, 20'h0001D, "sra");
    drive(32'h00007033, 1'b1, 1'b0, 1'b0, 20'h00025, 20'h00025, "and");
    drive(32'h00006013, 1'b1, 1'b0, 1'b0, 20'h00421, 20'h00421, "ori");
    drive(32'h00003013, 1'b1, 1'b0, 1'b0, 20'h00411, 20'h00411, "sltiu");
    drive(32'h00007063, 1'b1, 1'b0, 1'b0, 20'h1F000, 20'h1F000, "bgeu");
    drive(32'h00004003, 1'b1, 1'b0, 1'b0, 20'h09403, 20'h09403, "lbu");

    // Illegal encodings
    drive(32'h00000000, 1'b1, 1'b0, 1'b0, 20'h80000, 20'h80000, "zero");
    drive(32'h00003003, 1'b1, 1'b0, 1'b0, 20'h80000, 20'h80000, "load_f3_011");
    drive(32'h00003023, 1'b1, 1'b0, 1'b0, 20'h80000, 20'h80000, "store_f3_011");
    drive(32'h00002063, 1'b1, 1'b0, 1'b0, 20'h80000, 20'h80000, "branch_f3_010");
    drive(32'h00001067, 1'b1, 1'b0, 1'b0, 20'h80000, 20'h80000, "jalr_f3_001");

    // funct7 strictness
    drive(32'h02000033, 1'b1, 1'b0, 1'b0, EXP_F7_ADD, EXP_F7_ADD, "add_f7_01");
    drive(32'h02001013, 1'b1, 1'b0, 1'b0, EXP_F7_SLLI, EXP_F7_SLLI, "slli_imm_01");

    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_control_decoder.md
Name: rv32i_control_decoder

Overview:
- Main instruction decoder for the RV32I core, placed in the ID stage.
- Maps a 32-bit instruction word to a packed 20-bit control word. The decode is combinational.
- Also holds a registered copy of the control word for the ID/EX boundary. That copy supports stall and flush.

Parameters:
- CTRL_W, 20, width of the control word; fixed, must match `CONTROL_SIGNALS_WIDTH.

Ports:
- clk  input  1  sole clock; rising edge.
- rst_n  input  1  synchronous, active-low reset.
- instruction  input  32  instruction word in ID.
- stall  input  1  hold control_signals_q.
- flush  input  1  load a bubble into control_signals_q.
- control_signals  output  20  combinational decode of instruction.
- control_signals_q  output  20  registered control word for EX.

Behaviour:
- Control word bit map:
  - [19] illegal
  - [18] result_sel[1]
  - [17] jump
  - [16] branch
  - [15:12] mem_br_op
  - [11] alu_a_pc
  - [10] alu_b_imm
  - [9:6] reserved, always 0
  - [5:2] alu_ctrl
  - [1] result_sel[0]
  - [0] reg_write
- result_sel: 00=ALU, 01=memory data, 11=PC+4; 10 is never produced.
- alu_ctrl codes:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011
  - SLTU 0100, XOR 0101, SRL 0110, SRA 0111
  - OR 1000, AND 1001, PASS_B 1010
- mem_br_op codes:
  - 0000 none
  - Branches: 0001 BEQ, 0101 BNE, 0110 BLT, 0111 BGE, 1110 BLTU, 1111 BGEU
  - Loads: 0010 LB, 0100 LH, 0011 LW, 1001 LBU, 1101 LHU
  - Stores: 1010 SB, 1011 SH, 1100 SW
  - 1000 is never produced.
- Decode by opcode. Bits not listed are 0.
  - OP 0110011: reg_write=1; alu_ctrl from funct3/funct7[5] (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND).
  - OP-IMM 0010011: reg_write=1, alu_b_imm=1; alu_ctrl from funct3. funct7[5] selects SRA vs SRL for funct3=101; SUB is never produced here.
  - LOAD 0000011: reg_write=1, result_sel=01, alu_b_imm=1, ADD, mem_br_op per funct3.
  - STORE 0100011: alu_b_imm=1, ADD, mem_br_op per funct3.
  - BRANCH 1100011: branch=1, mem_br_op per funct3, alu_ctrl=ADD. The comparator takes the condition from mem_br_op.
  - JAL 1101111: reg_write=1, jump=1, result_sel=11; target is PC+imm because alu_b_imm=0.
  - JALR 1100111 with funct3=000: as JAL plus alu_b_imm=1; target is the ALU result rs1+imm.
  - LUI 0110111: reg_write=1, alu_b_imm=1, PASS_B.
  - AUIPC 0010111: reg_write=1, alu_a_pc=1, alu_b_imm=1, ADD.
- Illegal encodings produce exactly 20'h80000: illegal=1, all other bits 0, reg_write=0. These are:
  - any other opcode, including 0x00000000;
  - reserved funct3 in LOAD (011, 110, 111), STORE (>=011), BRANCH (010, 011), JALR (!=000).
- rd=x0 does not clear reg_write; the register file ignores x0 writes.
- control_signals has zero latency; it is purely combinational from instruction.
- control_signals_q updates on the rising clk edge. Priority on that edge, highest first:
  1. rst_n=0: load 0.
  2. flush=1: load 0.
  3. stall=1: hold current value.
  4. Otherwise: load control_signals.
- If flush and stall are both 1, flush wins.
- control_signals_q reset value is 20'h00000. control_signals has no reset; it follows instruction at all times.

Optional Feature:
- Macro: CU_STRICT_FUNCT7_EN.
- When defined, these encodings decode as illegal (20'h80000):
  - OP with funct7 other than 0000000, or other than 0100000 for ADD/SUB and SRL/SRA;
  - OP-IMM shifts with imm[11:5] other than 0000000, or other than 0100000 for SRAI.
- When not defined, only funct7[5] is examined and the remaining funct7 bits are ignored.

Test Plan:
- Decode the baseline set, checking control_signals 1 ns after each change:
  - 0x00000033 ADD -> 0x00001
  - 0x00000013 ADDI -> 0x00401
  - 0x00002003 LW -> 0x03403
  - 0x00002023 SW -> 0x0C400
  - 0x00000063 BEQ -> 0x11000
  - 0x0000006F JAL -> 0x60003
- Decode further ops:
  - 0x40000033 SUB -> 0x00005
  - 0x00000067 JALR -> 0x60403
  - 0x000000B7 LUI -> 0x00429
  - 0x00001063 BNE -> 0x15000
- Illegal encodings: 0x00000000 -> 0x80000; 0x00003003 (LOAD funct3=011) -> 0x80000.
- Register reset: rst_n=0 for one edge with instruction=LW -> control_signals_q=0x00000. After release, the next edge gives 0x03403.
- Stall/flush: with q=0x03403, apply instruction=SW and stall=1 -> q stays 0x03403. Then stall=1 and flush=1 together -> q=0x00000 (flush wins).
- Strict funct7: instruction 0x02000033.
  - With CU_STRICT_FUNCT7_EN -> 0x80000.
  - Without it -> 0x00001.
